// File: rtl/alu_rr_sched.sv
// alu_rr_sched: two requesters share one small ALU under round-robin arbitration.
// One operation in flight; IDLE -> EXEC -> RESP, result held until taken.
module alu_rr_sched #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [1:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [1:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W:0]   rsp0_data,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W:0]   rsp1_data,
   output logic              busy,
   output logic [CNT_W-1:0]  done_cnt
);

   localparam int unsigned RES_W = DATA_W + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_AND = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              ptr_q, ptr_d;
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [RES_W-1:0]  res_q, res_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              any_valid_c;
   logic              gnt_c;
   logic              rsp_hs_c;
   logic [RES_W-1:0]  alu_c;

   // Grant selection: a lone requester wins, otherwise the priority pointer decides
   always_comb begin
      any_valid_c = req0_valid | req1_valid;
      gnt_c       = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_c = ptr_q;
      end else if (req1_valid) begin
         gnt_c = 1'b1;
      end
   end

   // ALU on the latched operands
   always_comb begin
      alu_c = '1;
      case (op_q)
         OP_ADD:  alu_c = RES_W'(a_q) + RES_W'(b_q);
         OP_AND:  alu_c = RES_W'(a_q & b_q);
         OP_XOR:  alu_c = RES_W'(a_q ^ b_q);
         default: alu_c = '1;
      endcase
   end

   // Next-state and datapath updates
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      ptr_d    = ptr_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      rsp_hs_c = (state_q == RESP) && (gnt_q ? rsp1_ready : rsp0_ready);
      case (state_q)
         IDLE: begin
            if (any_valid_c) begin
               state_d = EXEC;
               gnt_d   = gnt_c;
               op_d    = gnt_c ? req1_op : req0_op;
               a_d     = gnt_c ? req1_a  : req0_a;
               b_d     = gnt_c ? req1_b  : req0_b;
            end
         end
         EXEC: begin
            res_d   = alu_c;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_hs_c) begin
               state_d = IDLE;
               cnt_d   = cnt_q + CNT_W'(1);
               ptr_d   = ~gnt_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         ptr_q   <= 1'b0;
         op_q    <= 2'd0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake outputs decoded from registered state
   always_comb begin
      req0_ready = (state_q == IDLE) && any_valid_c && !gnt_c;
      req1_ready = (state_q == IDLE) && any_valid_c &&  gnt_c;
      rsp0_valid = (state_q == RESP) && !gnt_q;
      rsp1_valid = (state_q == RESP) &&  gnt_q;
      rsp0_data  = rsp0_valid ? res_q : '0;
      rsp1_data  = rsp1_valid ? res_q : '0;
      busy       = (state_q != IDLE);
      done_cnt   = cnt_q;
   end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed self-checking bench for alu_rr_sched.
// A second instance with a 2-bit counter shares the stimulus to observe wrap.
module tb_alu_rr_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [1:0] req0_op = 2'd0, req1_op = 2'd0;
   logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
   logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
   logic [4:0] rsp0_data, rsp1_data;
   logic [7:0] done_cnt;
   logic       w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_busy;
   logic [4:0] w_rsp0_data, w_rsp1_data;
   logic [1:0] w_done_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_rr_sched #(.DATA_W(4), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .busy(busy), .done_cnt(done_cnt)
   );

   alu_rr_sched #(.DATA_W(4), .CNT_W(2)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(w_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(w_rsp0_data),
      .rsp1_valid(w_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(w_rsp1_data),
      .busy(w_busy), .done_cnt(w_done_cnt)
   );

   // Single comparison point
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic set_req(input bit id, input logic v, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b);
      if (id) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
      else    begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
   endtask

   // Full transaction on one requester with bounded waits
   task automatic do_op(input string tag, input bit id, input logic [1:0] op,
                        input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp);
      int n;
      set_req(id, 1'b1, op, a, b);
      #1;
      n = 0;
      while (!(id ? req1_ready : req0_ready) && n < 8) begin tick(); n++; end
      chk({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
      tick();
      set_req(id, 1'b0, 2'd0, 4'd0, 4'd0);
      n = 0;
      while (!(id ? rsp1_valid : rsp0_valid) && n < 8) begin tick(); n++; end
      chk({tag, "_valid"}, 32'(id ? rsp1_valid : rsp0_valid), 32'd1);
      chk({tag, "_data"}, 32'(id ? rsp1_data : rsp0_data), 32'(exp));
      if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
   endtask

   initial begin
      // 1: reset state
      rst_n = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(done_cnt), 32'd0);
      chk("rst_outs", {27'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, 1'b0}, 32'd0);
      chk("rst_data", {22'd0, rsp0_data, rsp1_data}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 2: single add with carry, exact latency
      set_req(1'b0, 1'b1, 2'd0, 4'hF, 4'h1);
      #1;
      chk("t2_ready", 32'(req0_ready), 32'd1);
      chk("t2_ready1", 32'(req1_ready), 32'd0);
      tick();
      set_req(1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
      chk("t2_exec_busy", 32'(busy), 32'd1);
      chk("t2_exec_ready", 32'(req0_ready), 32'd0);
      chk("t2_exec_valid", 32'(rsp0_valid), 32'd0);
      tick();
      chk("t2_rsp_valid", 32'(rsp0_valid), 32'd1);
      chk("t2_rsp_data", 32'(rsp0_data), 32'h10);
      chk("t2_rsp1_valid", 32'(rsp1_valid), 32'd0);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      chk("t2_cnt", 32'(done_cnt), 32'd1);
      chk("t2_idle", 32'(busy), 32'd0);

      // 3: simultaneous requests, round-robin order
      do_reset();
      set_req(1'b0, 1'b1, 2'd2, 4'hA, 4'h5);
      set_req(1'b1, 1'b1, 2'd1, 4'hC, 4'hA);
      #1;
      chk("t3_g0_r0", 32'(req0_ready), 32'd1);
      chk("t3_g0_r1", 32'(req1_ready), 32'd0);
      tick();
      set_req(1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
      tick();
      chk("t3_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("t3_rsp0_data", 32'(rsp0_data), 32'h0F);
      chk("t3_rsp1_quiet", 32'(rsp1_valid), 32'd0);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      set_req(1'b0, 1'b1, 2'd0, 4'h3, 4'h4);
      #1;
      chk("t3_g1_r1", 32'(req1_ready), 32'd1);
      chk("t3_g1_r0", 32'(req0_ready), 32'd0);
      tick();
      set_req(1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
      tick();
      chk("t3_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("t3_rsp1_data", 32'(rsp1_data), 32'h08);
      rsp1_ready = 1'b1;
      tick();
      rsp1_ready = 1'b0;
      set_req(1'b1, 1'b1, 2'd3, 4'h0, 4'h0);
      #1;
      chk("t3_g2_r0", 32'(req0_ready), 32'd1);
      chk("t3_g2_r1", 32'(req1_ready), 32'd0);
      set_req(1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
      do_op("t3_third", 1'b0, 2'd0, 4'h3, 4'h4, 5'h07);
      chk("t3_cnt", 32'(done_cnt), 32'd3);

      // 4: response backpressure with a competing request
      do_reset();
      set_req(1'b1, 1'b1, 2'd3, 4'h2, 4'h6);
      #1;
      chk("t4_ready1", 32'(req1_ready), 32'd1);
      tick();
      set_req(1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
      set_req(1'b0, 1'b1, 2'd0, 4'h1, 4'h1);
      #1;
      chk("t4_exec_r0", 32'(req0_ready), 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", 32'(rsp1_valid), 32'd1);
         chk("t4_hold_data", 32'(rsp1_data), 32'h1F);
         chk("t4_hold_r0", 32'(req0_ready), 32'd0);
         tick();
      end
      rsp1_ready = 1'b1;
      #1;
      chk("t4_hs_valid", 32'(rsp1_valid), 32'd1);
      tick();
      rsp1_ready = 1'b0;
      chk("t4_after_r0", 32'(req0_ready), 32'd1);
      chk("t4_cnt", 32'(done_cnt), 32'd1);
      set_req(1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
      #1;

      // 5: counter wrap on the 2-bit instance
      do_reset();
      do_op("t5_op1", 1'b0, 2'd0, 4'h7, 4'h8, 5'h0F);
      chk("t5_w1", 32'(w_done_cnt), 32'd1);
      do_op("t5_op2", 1'b1, 2'd2, 4'hF, 4'h3, 5'h0C);
      chk("t5_w2", 32'(w_done_cnt), 32'd2);
      do_op("t5_op3", 1'b0, 2'd1, 4'h6, 4'h3, 5'h02);
      chk("t5_w3", 32'(w_done_cnt), 32'd3);
      do_op("t5_op4", 1'b1, 2'd0, 4'h8, 4'h8, 5'h10);
      chk("t5_w0", 32'(w_done_cnt), 32'd0);
      chk("t5_main", 32'(done_cnt), 32'd4);

      // 6: reset during EXEC discards the operation
      set_req(1'b0, 1'b1, 2'd0, 4'h5, 4'h5);
      #1;
      chk("t6_ready", 32'(req0_ready), 32'd1);
      tick();
      set_req(1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
      chk("t6_exec", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_cnt", 32'(done_cnt), 32'd0);
      chk("t6_valid", 32'(rsp0_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_no_rsp", 32'(rsp0_valid), 32'd0);
      end
      chk("t6_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
